buffer_weight_1xn_loader: RTL and testbench

- N-channel 3x3 weight buffer with an integrated stream loader.
- Accepts a single valid/ready stream of packed weight words and scatters them round-robin into CH simple-dual-port RAM banks.
- Provides one shared read address that returns all CH words in parallel for the conv PE array.
- Sits between the DDR/DMA weight fetcher and the conv compute array.

---
 rtl/buffer_weight_1xn_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_buffer_weight_1xn_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_weight_1xn_loader.sv
// buffer_weight_1xn_loader
// CH-bank 3x3 weight buffer with a round-robin stream loader and one shared
// row-address read port returning all CH words in parallel (latency 1).
// Optional feature macro: WEIGHT_PINGPONG_EN -- each bank holds two halves;
// loads fill the hidden half and the halves swap when a load completes.

// Simple dual-port RAM: one write port, one registered read-first read port.
module com_simple_dual_port_ram #(
   parameter int WIDTH     = 36,
   parameter int DEPTH     = 512,
   parameter int AW        = 9,
   parameter     RAM_STYLE = "block"
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);
   logic [WIDTH-1:0] w_rd;
   logic [WIDTH-1:0] r_q;

   if (RAM_STYLE == "block") begin : g_block
      (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [DEPTH];
      // write port
      always_ff @(posedge i_clk) begin
         if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
         end
      end
      assign w_rd = r_mem[i_raddr];
   end else begin : g_dist
      (* ram_style = "distributed" *) logic [WIDTH-1:0] r_mem [DEPTH];
      // write port
      always_ff @(posedge i_clk) begin
         if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
         end
      end
      assign w_rd = r_mem[i_raddr];
   end

   // read register samples the pre-write contents (read-first), holds when idle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= {WIDTH{1'b0}};
      end else if (i_re) begin
         r_q <= w_rd;
      end
   end

   assign o_rdata = r_q;
endmodule

module buffer_weight_1xn_loader #(
   parameter int CH            = 8,
   parameter int WIDTH         = 36,
   parameter int DEPTH         = 512,
   parameter int ADDR_BIT      = 9,
   parameter     RAM_STYLE_VAL = "block"
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_start,
   input  logic [ADDR_BIT:0]   load_num,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [WIDTH-1:0]    s_data,
   output logic                load_busy,
   output logic                load_done,
   input  logic                read_en,
   input  logic [ADDR_BIT-1:0] read_addr,
   output logic [CH*WIDTH-1:0] weight_out,
   output logic                weight_valid
);
   localparam int                CH_W    = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [ADDR_BIT:0] DEPTH_N = (ADDR_BIT+1)'(DEPTH);
   localparam logic [CH_W-1:0]   CH_LAST = CH_W'(CH - 1);
`ifdef WEIGHT_PINGPONG_EN
   localparam int MEM_AW    = ADDR_BIT + 1;
   localparam int MEM_DEPTH = 2 * DEPTH;
`else
   localparam int MEM_AW    = ADDR_BIT;
   localparam int MEM_DEPTH = DEPTH;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [CH_W-1:0]     r_ch_cnt, w_ch_cnt_nxt;
   logic [ADDR_BIT-1:0] r_row_cnt, w_row_cnt_nxt;
   logic [ADDR_BIT:0]   r_num, w_num_nxt, w_num_clamped;
   logic                r_s_ready, r_load_busy, r_load_done, r_weight_valid;
   logic                w_hs, w_last;
   logic [CH-1:0]       w_we;
   logic [MEM_AW-1:0]   w_waddr, w_raddr;

   // rows beyond the bank depth cannot be stored, so the request is clamped
   assign w_num_clamped = (load_num > DEPTH_N) ? DEPTH_N : load_num;
   // s_ready is high exactly in LOAD, so this is the stream handshake
   assign w_hs   = r_s_ready & s_valid;
   assign w_last = (r_ch_cnt == CH_LAST) &&
                   ({1'b0, r_row_cnt} == (r_num - {{ADDR_BIT{1'b0}}, 1'b1}));

   // next-state and counter logic of the loader
   always_comb begin
      w_state_nxt   = r_state;
      w_ch_cnt_nxt  = r_ch_cnt;
      w_row_cnt_nxt = r_row_cnt;
      w_num_nxt     = r_num;
      case (r_state)
         ST_IDLE: begin
            if (load_start) begin
               if (w_num_clamped != {(ADDR_BIT+1){1'b0}}) begin
                  w_num_nxt     = w_num_clamped;
                  w_ch_cnt_nxt  = {CH_W{1'b0}};
                  w_row_cnt_nxt = {ADDR_BIT{1'b0}};
                  w_state_nxt   = ST_LOAD;
               end else begin
                  w_state_nxt = ST_DONE;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (w_hs) begin
               if (r_ch_cnt == CH_LAST) begin
                  w_ch_cnt_nxt  = {CH_W{1'b0}};
                  w_row_cnt_nxt = r_row_cnt + {{(ADDR_BIT-1){1'b0}}, 1'b1};
               end else begin
                  w_ch_cnt_nxt = r_ch_cnt + {{(CH_W-1){1'b0}}, 1'b1};
               end
               if (w_last) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_LOAD;
               end
            end else begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // state, counters and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_ch_cnt       <= {CH_W{1'b0}};
         r_row_cnt      <= {ADDR_BIT{1'b0}};
         r_num          <= {(ADDR_BIT+1){1'b0}};
         r_s_ready      <= 1'b0;
         r_load_busy    <= 1'b0;
         r_load_done    <= 1'b0;
         r_weight_valid <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_ch_cnt       <= w_ch_cnt_nxt;
         r_row_cnt      <= w_row_cnt_nxt;
         r_num          <= w_num_nxt;
         r_s_ready      <= (w_state_nxt == ST_LOAD);
         r_load_busy    <= (w_state_nxt == ST_LOAD);
         r_load_done    <= (w_state_nxt == ST_DONE);
         r_weight_valid <= read_en;
      end
   end

`ifdef WEIGHT_PINGPONG_EN
   logic r_sel;

   // swap halves at the end of the load_done cycle; reset returns to half 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel <= 1'b0;
      end else if (r_state == ST_DONE) begin
         r_sel <= ~r_sel;
      end
   end

   assign w_waddr = {~r_sel, r_row_cnt};
   assign w_raddr = {r_sel, read_addr};
`else
   assign w_waddr = r_row_cnt;
   assign w_raddr = read_addr;
`endif

   // one-hot bank write enable, only on an accepted word
   always_comb begin
      w_we = {CH{1'b0}};
      for (int c = 0; c < CH; c++) begin
         if (w_hs && (r_ch_cnt == CH_W'(c))) begin
            w_we[c] = 1'b1;
         end else begin
            w_we[c] = 1'b0;
         end
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_bank
      com_simple_dual_port_ram #(
         .WIDTH    (WIDTH),
         .DEPTH    (MEM_DEPTH),
         .AW       (MEM_AW),
         .RAM_STYLE(RAM_STYLE_VAL)
      ) u_ram (
         .i_clk  (clk),
         .i_rst_n(rst_n),
         .i_we   (w_we[c]),
         .i_waddr(w_waddr),
         .i_wdata(s_data),
         .i_re   (read_en),
         .i_raddr(w_raddr),
         .o_rdata(weight_out[c*WIDTH +: WIDTH])
      );
   end

   assign s_ready      = r_s_ready;
   assign load_busy    = r_load_busy;
   assign load_done    = r_load_done;
   assign weight_valid = r_weight_valid;
endmodule

// File: tb/tb_buffer_weight_1xn_loader.sv
// Self-checking bench for buffer_weight_1xn_loader: randomized loads checked
// against a row/channel array model filled word-by-word in stream order.
module tb_buffer_weight_1xn_loader;
   localparam int CH       = 8;
   localparam int WIDTH    = 36;
   localparam int DEPTH    = 512;
   localparam int ADDR_BIT = 9;
`ifdef WEIGHT_PINGPONG_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                load_start = 1'b0;
   logic [ADDR_BIT:0]   load_num = '0;
   logic                s_valid = 1'b0;
   logic                s_ready;
   logic [WIDTH-1:0]    s_data = '0;
   logic                load_busy;
   logic                load_done;
   logic                read_en = 1'b0;
   logic [ADDR_BIT-1:0] read_addr = '0;
   logic [CH*WIDTH-1:0] weight_out;
   logic                weight_valid;

   int n_tests = 0;
   int n_fail  = 0;
   int sel_m   = 0;
   logic [WIDTH-1:0] model_mem [2][CH][DEPTH];

   buffer_weight_1xn_loader #(
      .CH(CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BIT(ADDR_BIT), .RAM_STYLE_VAL("block")
   ) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_num(load_num),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .load_busy(load_busy), .load_done(load_done),
      .read_en(read_en), .read_addr(read_addr),
      .weight_out(weight_out), .weight_valid(weight_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] rnd_word();
      return WIDTH'({$urandom, $urandom});
   endfunction

   // k-th word of a load goes to channel k%CH, row k/CH of the hidden half
   function automatic void model_write(input int k, input logic [WIDTH-1:0] w);
      int h;
      h = PP ? (sel_m == 0 ? 1 : 0) : 0;
      if (k / CH < DEPTH) model_mem[h][k % CH][k / CH] = w;
   endfunction

   function automatic logic [CH*WIDTH-1:0] model_row(input int a);
      logic [CH*WIDTH-1:0] r;
      int h;
      h = PP ? sel_m : 0;
      for (int c = 0; c < CH; c++) r[c*WIDTH +: WIDTH] = model_mem[h][c][a];
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] next_word(input int dmode, input logic [WIDTH-1:0] base, input int k);
      if (dmode == 0) return WIDTH'(k);
      else if (dmode == 1) return rnd_word();
      else return base;
   endfunction

   // vpat: 0 valid held, 1 toggling, 2 random. dmode: 0 index, 1 random, 2 constant.
   task automatic run_load(input int num, input int vpat, input int dmode, input logic [WIDTH-1:0] base,
                           input bit rd_on, input int glitch_at, input bit done_start,
                           output int n_hs, output int lat, output bit done_seen, output bit rdy_seen);
      logic [WIDTH-1:0]    word;
      logic [CH*WIDTH-1:0] rd_exp;
      bit                  rd_pend;
      n_hs = 0; lat = -1; done_seen = 1'b0; rdy_seen = 1'b0; rd_pend = 1'b0;
      rd_exp = '0;
      word = next_word(dmode, base, 0);
      load_start = 1'b1;
      load_num = num[ADDR_BIT:0];
      tick();
      load_start = 1'b0;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         if (rd_pend) begin
            n_tests++;
            if (weight_valid !== 1'b1 || weight_out !== rd_exp) begin
               n_fail++;
               $display("FAIL load_read cyc=%0d got=%h valid=%b exp=%h", cyc, weight_out, weight_valid, rd_exp);
            end
            rd_pend = 1'b0;
         end
         if (load_done === 1'b1) begin
            done_seen = 1'b1;
            lat = cyc;
            break;
         end
         if (s_ready === 1'b1) rdy_seen = 1'b1;
         load_start = (cyc == glitch_at);
         load_num = ADDR_BIT'($urandom_range(1, 20));
         if (vpat == 0) s_valid = 1'b1;
         else if (vpat == 1) s_valid = (cyc % 2 == 0);
         else s_valid = ($urandom % 2 == 0);
         s_data = s_valid ? word : rnd_word();
         if (rd_on) begin
            read_en = 1'b1;
            read_addr = '0;
            rd_exp = model_row(0);
            rd_pend = 1'b1;
         end
         if (s_valid && s_ready) begin
            model_write(n_hs, word);
            n_hs++;
            word = next_word(dmode, base, n_hs);
         end
         tick();
      end
      s_valid = 1'b0;
      load_start = 1'b0;
      if (done_seen) begin
         if (done_start) begin
            load_start = 1'b1;
            load_num = 3;
         end
         if (rd_on) begin
            rd_exp = model_row(0);
            rd_pend = 1'b1;
         end
         tick();
         load_start = 1'b0;
         if (PP) sel_m = (sel_m == 0) ? 1 : 0;
         n_tests++;
         if (load_done !== 1'b0 || load_busy !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done done=%b busy=%b ready=%b exp=0/0/0", load_done, load_busy, s_ready);
         end
         if (rd_pend) begin
            n_tests++;
            if (weight_out !== rd_exp) begin
               n_fail++;
               $display("FAIL done_cycle_read got=%h exp=%h", weight_out, rd_exp);
            end
         end
      end
      read_en = 1'b0;
   endtask

   task automatic check_read(input int a, input string tag);
      logic [CH*WIDTH-1:0] exp;
      exp = model_row(a);
      read_en = 1'b1;
      read_addr = a[ADDR_BIT-1:0];
      tick();
      read_en = 1'b0;
      n_tests++;
      if (weight_valid !== 1'b1 || weight_out !== exp) begin
         n_fail++;
         $display("FAIL %s_read addr=%0d valid=%b got=%h exp=%h", tag, a, weight_valid, weight_out, exp);
      end
      tick();
      n_tests++;
      if (weight_valid !== 1'b0 || weight_out !== exp) begin
         n_fail++;
         $display("FAIL %s_hold addr=%0d valid=%b got=%h exp=%h", tag, a, weight_valid, weight_out, exp);
      end
   endtask

   task automatic check_load(input string tag, input int n_hs, input int exp_hs, input bit done_seen,
                             input int lat, input int exp_lat);
      n_tests++;
      if (n_hs != exp_hs || done_seen !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_count words=%0d done=%b exp words=%0d done=1", tag, n_hs, done_seen, exp_hs);
      end
      if (exp_lat >= 0) begin
         n_tests++;
         if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, exp_lat);
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) tick();
      n_tests++;
      if (s_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0 ||
          weight_valid !== 1'b0 || weight_out !== '0) begin
         n_fail++;
         $display("FAIL reset ready=%b busy=%b done=%b wvalid=%b wout=%h exp all 0",
                  s_ready, load_busy, load_done, weight_valid, weight_out);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_load();
      int n, lat; bit d, r;
      run_load(2, 0, 0, '0, 1'b0, -1, 1'b0, n, lat, d, r);
      check_load("basic", n, 16, d, lat, 16);
      check_read(0, "basic_row0");
      check_read(1, "basic_row1");
   endtask

   task automatic test_backpressure();
      int n, lat; bit d, r;
      run_load(1, 1, 1, '0, 1'b0, -1, 1'b0, n, lat, d, r);
      check_load("backpressure", n, 8, d, lat, 15);
      check_read(0, "backpressure");
   endtask

   task automatic test_zero_len();
      int n, lat; bit d, r;
      run_load(0, 0, 1, '0, 1'b0, -1, 1'b0, n, lat, d, r);
      check_load("zero_len", n, 0, d, lat, 0);
      n_tests++;
      if (r !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len_ready got=%b exp=0", r);
      end
      check_read(0, "zero_len");
   endtask

   task automatic test_idle_stream();
      s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_data = rnd_word();
         tick();
         n_tests++;
         if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready cyc=%0d got=%b exp=0", i, s_ready);
         end
      end
      s_valid = 1'b0;
      check_read(1, "idle_stream");
   endtask

   task automatic test_ignored_start();
      int n, lat; bit d, r;
      run_load(2, 0, 1, '0, 1'b0, 3, 1'b1, n, lat, d, r);
      check_load("ignored_start", n, 16, d, lat, 16);
      check_read(1, "ignored_start");
   endtask

   task automatic test_clamp();
      int n, lat; bit d, r;
      run_load(600, 0, 1, '0, 1'b0, -1, 1'b0, n, lat, d, r);
      check_load("clamp", n, DEPTH * CH, d, lat, DEPTH * CH);
      check_read(0, "clamp_first");
      check_read(DEPTH / 2, "clamp_mid");
      check_read(DEPTH - 1, "clamp_last");
   endtask

   task automatic test_abort();
      int n, lat, k; bit d, r;
      load_start = 1'b1;
      load_num = 2;
      tick();
      load_start = 1'b0;
      k = 0;
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_data = rnd_word();
         if (s_ready) begin
            model_write(k, s_data);
            k++;
         end
         tick();
      end
      s_valid = 1'b0;
      rst_n = 1'b0;
      sel_m = 0;
      #1;
      n_tests++;
      if (k != 5 || s_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0 ||
          weight_valid !== 1'b0 || weight_out !== '0) begin
         n_fail++;
         $display("FAIL abort_reset words=%0d ready=%b busy=%b done=%b wvalid=%b wout=%h exp 5 and all 0",
                  k, s_ready, load_busy, load_done, weight_valid, weight_out);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if (load_done !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle cyc=%0d done=%b ready=%b exp 0/0", i, load_done, s_ready);
         end
      end
      check_read(0, "abort_partial");
      run_load(1, 0, 1, '0, 1'b0, -1, 1'b0, n, lat, d, r);
      check_load("abort_reload", n, 8, d, lat, 8);
      check_read(0, "abort_reload");
   endtask

   task automatic test_random();
      int n, lat, num; bit d, r;
      for (int it = 0; it < 6; it++) begin
         num = $urandom_range(1, 8);
         run_load(num, 2, 1, '0, 1'($urandom % 2), -1, 1'b0, n, lat, d, r);
         check_load("random", n, num * CH, d, lat, -1);
         check_read($urandom_range(0, num - 1), "random");
      end
   endtask

   task automatic test_pingpong();
      int n, lat; bit d, r;
      logic [WIDTH-1:0]    a_w, b_w;
      logic [CH*WIDTH-1:0] a_row, b_row;
      a_w = WIDTH'(4'hA);
      b_w = WIDTH'(4'hB);
      a_row = {CH{a_w}};
      b_row = {CH{b_w}};
      run_load(2, 0, 2, a_w, 1'b0, -1, 1'b0, n, lat, d, r);
      check_load("pp_load_a", n, 16, d, lat, 16);
      check_read(0, "pp_a");
      n_tests++;
      if (weight_out !== a_row) begin
         n_fail++;
         $display("FAIL pp_a_const got=%h exp=%h", weight_out, a_row);
      end
      run_load(2, 0, 2, b_w, 1'b1, -1, 1'b0, n, lat, d, r);
      check_load("pp_load_b", n, 16, d, lat, 16);
      n_tests++;
      if (weight_out !== a_row) begin
         n_fail++;
         $display("FAIL pp_before_swap got=%h exp=%h", weight_out, a_row);
      end
      check_read(0, "pp_b");
      n_tests++;
      if (weight_out !== b_row) begin
         n_fail++;
         $display("FAIL pp_after_swap got=%h exp=%h", weight_out, b_row);
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_backpressure();
      test_zero_len();
      test_idle_stream();
      test_ignored_start();
      test_clamp();
      test_abort();
      test_random();
      if (PP) test_pingpong();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
